// File: rtl/store_ctrl_if.sv
// Store-path bundle: execute-stage store port, data-memory write port and load-hazard probe.
interface store_ctrl_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          sb_en;
  logic          sh_en;
  logic          sw_en;
  logic          st_err;
  logic          mem_req;
  logic          mem_ack;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_bmask;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic [CW-1:0] count;
  logic          empty;

  // Core/memory side
  modport master (
    output st_valid, st_addr, st_data, sb_en, sh_en, sw_en, mem_ack, ld_addr,
    input  st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_bmask, ld_hazard, count, empty
  );

  // Controller side
  modport slave (
    input  st_valid, st_addr, st_data, sb_en, sh_en, sw_en, mem_ack, ld_addr,
    output st_ready, st_err, mem_req, mem_addr, mem_wdata, mem_bmask, ld_hazard, count, empty
  );
endinterface

// File: rtl/store_ctrl.sv
// Store-path controller: aligns stores into byte lanes, queues them in order and drains over req/ack.
// Define STORE_HAZARD_EN to build the load-vs-pending-store word comparators on ld_hazard.
module store_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  store_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  entry_t        q [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  state_t        state;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_bmask_q;
  logic          st_err_q;

  logic [2:0]    sel;
  logic          sel_ok;
  logic          align_ok;
  logic          legal;
  logic          ready;
  logic          push;
  logic          reject;
  logic          pop;
  entry_t        in_e;
  logic          load;
  entry_t        load_e;
  logic [AW-1:0] head_nx;

  // Lane alignment and legality of the incoming store
  always_comb begin
    sel      = {bus.sb_en, bus.sh_en, bus.sw_en};
    sel_ok   = (sel == 3'b100) || (sel == 3'b010) || (sel == 3'b001);
    align_ok = 1'b1;
    in_e     = '{word: bus.st_addr[31:2], data: bus.st_data, mask: 4'b1111};
    if (bus.sb_en) begin
      in_e.data = {4{bus.st_data[7:0]}};
      in_e.mask = 4'b0001 << bus.st_addr[1:0];
    end else if (bus.sh_en) begin
      in_e.data = {2{bus.st_data[15:0]}};
      in_e.mask = bus.st_addr[1] ? 4'b1100 : 4'b0011;
      align_ok  = !bus.st_addr[0];
    end else begin
      align_ok  = (bus.st_addr[1:0] == 2'b00);
    end
    legal = sel_ok && align_ok;
  end

  assign ready   = !rst && (count < CW'(DEPTH));
  assign push    = bus.st_valid && ready && legal;
  assign reject  = bus.st_valid && ready && !legal;
  assign pop     = (state == ISSUE) && bus.mem_ack;
  assign head_nx = head + AW'(1);

  // Pick the entry presented next; a same-cycle push covers an otherwise empty queue
  always_comb begin
    load   = 1'b0;
    load_e = in_e;
    if (state == IDLE) begin
      if (count != '0) begin
        load   = 1'b1;
        load_e = q[head];
      end else if (push) begin
        load   = 1'b1;
      end
    end else if (pop) begin
      if (count > CW'(1)) begin
        load   = 1'b1;
        load_e = q[head_nx];
      end else if (push) begin
        load   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[tail] <= in_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      st_err_q    <= 1'b0;
    end else begin
      st_err_q <= reject;
      count    <= count + CW'(push) - CW'(pop);
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head_nx;
      if (load) begin
        state       <= ISSUE;
        mem_req_q   <= 1'b1;
        mem_addr_q  <= {load_e.word, 2'b00};
        mem_wdata_q <= load_e.data;
        mem_bmask_q <= load_e.mask;
      end else if (pop) begin
        state     <= IDLE;
        mem_req_q <= 1'b0;
      end
    end
  end

`ifdef STORE_HAZARD_EN
  logic hazard;
  logic unused_ld;

  // Word match against every held entry, the in-flight head included
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count) && (q[head + AW'(i)].word == bus.ld_addr[31:2])) hazard = 1'b1;
    end
  end

  assign bus.ld_hazard = hazard;
  assign unused_ld     = ^bus.ld_addr[1:0];
`else
  logic unused_ld;

  assign bus.ld_hazard = 1'b0;
  assign unused_ld     = ^bus.ld_addr;
`endif

  assign bus.st_ready  = ready;
  assign bus.st_err    = st_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_bmask = mem_bmask_q;
  assign bus.count     = count;
  assign bus.empty     = (count == '0);
endmodule
